// File: rtl/lcd_pkg.sv
// Shared types for the LCD 8080-style write path.
package lcd_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, LOW, HIGH} lcd_wr_state_t;

  localparam logic LCD_CMD  = 1'b0;
  localparam logic LCD_DATA = 1'b1;

  typedef struct packed {
    logic       dcx;
    logic [7:0] data;
  } lcd_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; count is one bit wider than the pointers so full is representable.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // flush wins over any push or pop in the same cycle
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lcd_bus_writer.sv
// Replays queued {dcx, byte} words on an 8080-style write bus with programmable WR low/high hold times.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WR_LOW_CYC  = 2,
  parameter int unsigned WR_HIGH_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_dcx,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       flush,
  output logic       wr,
  output logic       dcx,
  output logic [7:0] D,
  output logic       tx_done,
  output logic       idle
);

  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMAX = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  lcd_wr_state_t state;
  lcd_wr_state_t state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  lcd_word_t     in_word;
  lcd_word_t     head;
  logic          wr_next;
  logic          tx_done_next;
  logic          idle_next;

  assign in_ready = !full && !reset && !flush;
  assign push     = in_valid && in_ready;
  assign in_word  = {in_dcx, in_data};

  sync_fifo #(
    .WIDTH ($bits(lcd_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (in_word),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // State, hold timer and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      wr      <= 1'b1;
      dcx     <= LCD_DATA;
      D       <= 8'h00;
      tx_done <= 1'b0;
      idle    <= 1'b1;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      wr      <= wr_next;
      tx_done <= tx_done_next;
      idle    <= idle_next;
      if (pop) begin
        dcx <= head.dcx;
        D   <= head.data;
      end
    end
  end

  // Next-state: a flushed FIFO counts as empty for the pop decision
  always_comb begin
    state_next = state;
    timer_next = timer;
    unique case (state)
      IDLE: begin
        if (!empty && !flush) state_next = SETUP;
      end
      SETUP: begin
        state_next = LOW;
        timer_next = TW'(WR_LOW_CYC - 1);
      end
      LOW: begin
        if (timer == '0) begin
          state_next = HIGH;
          timer_next = TW'(WR_HIGH_CYC - 1);
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      HIGH: begin
        if (timer == '0) begin
          state_next = (!empty && !flush) ? SETUP : IDLE;
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: every entry into SETUP pops the head into D/dcx
  always_comb begin
    pop          = (state_next == SETUP);
    wr_next      = (state_next != LOW);
    tx_done_next = (state == LOW) && (state_next == HIGH);
    idle_next    = (state_next == IDLE) &&
                   (flush || ((count + CW'(push) - CW'(pop)) == '0));
  end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer: cycle tables plus scoreboarded multi-cycle sequences.
module tb_lcd_bus_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, in_dcx, flush;
  logic [7:0] in_data;
  logic       in_ready, wr, dcx, tx_done, idle;
  logic [7:0] D;

  logic       p_valid, p_dcx;
  logic [7:0] p_data;
  logic       p_ready, p_wr, p_dcx_o, p_tx, p_idle;
  logic [7:0] p_D;

  lcd_bus_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_dcx(in_dcx), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .wr(wr), .dcx(dcx), .D(D),
    .tx_done(tx_done), .idle(idle)
  );

  lcd_bus_writer #(.FIFO_DEPTH(4), .WR_LOW_CYC(1), .WR_HIGH_CYC(3)) dut_p (
    .clk(clk), .reset(reset), .in_valid(p_valid), .in_dcx(p_dcx), .in_data(p_data),
    .in_ready(p_ready), .flush(1'b0), .wr(p_wr), .dcx(p_dcx_o), .D(p_D),
    .tx_done(p_tx), .idle(p_idle)
  );

  typedef struct {
    logic        vld;
    logic        vdcx;
    logic [7:0]  vdata;
    logic [12:0] exp;   // {wr, dcx, D, tx_done, idle, in_ready}
  } vec_t;

  vec_t single_v[8];
  vec_t param_v[13];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int last_tx = 0;
  logic prev_wr = 1'b1;
  logic [8:0] prev_word = 9'h100;
  logic [8:0] exp_q[$];

  function automatic vec_t mk(input logic v, input logic vd, input logic [7:0] vdat,
                              input logic w, input logic c, input logic [7:0] d,
                              input logic t, input logic i, input logic r);
    vec_t x;
    x.vld = v; x.vdcx = vd; x.vdata = vdat;
    x.exp = {w, c, d, t, i, r};
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: record accepted pushes, advance, then check bus invariants and scoreboard.
  task automatic step();
    #2;
    if (in_valid && in_ready) exp_q.push_back({in_dcx, in_data});
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (!wr && !prev_wr) check("d_stable_low", {dcx, D}, prev_word);
      if (wr && !prev_wr)  check("d_stable_rise", {dcx, D}, prev_word);
      if (tx_done) begin
        check("tx_at_rise", prev_wr, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got dcx=%b D=%h expected no transfer (cycle %0d)", dcx, D, cyc);
        end else begin
          check("tx_word", {dcx, D}, exp_q.pop_front());
        end
        tx_cnt++;
        last_tx = cyc;
      end
    end
    prev_wr = wr;
    prev_word = {dcx, D};
  endtask

  initial begin
    int k, t0, start_tx, low_cnt, last_b;
    logic saw_full, prev_rdy;
    logic [8:0] w;

    reset = 1'b1; in_valid = 1'b0; in_dcx = 1'b0; in_data = 8'h00; flush = 1'b0;
    p_valid = 1'b0; p_dcx = 1'b0; p_data = 8'h00;

    //                    vld dcx data    wr dcx D      tx idle rdy
    single_v[0] = mk(1, 0, 8'h2A, 1, 1, 8'h00, 0, 1, 1);
    single_v[1] = mk(0, 0, 8'h00, 1, 1, 8'h00, 0, 0, 1);
    single_v[2] = mk(0, 0, 8'h00, 1, 0, 8'h2A, 0, 0, 1);
    single_v[3] = mk(0, 0, 8'h00, 0, 0, 8'h2A, 0, 0, 1);
    single_v[4] = mk(0, 0, 8'h00, 0, 0, 8'h2A, 0, 0, 1);
    single_v[5] = mk(0, 0, 8'h00, 1, 0, 8'h2A, 1, 0, 1);
    single_v[6] = mk(0, 0, 8'h00, 1, 0, 8'h2A, 0, 0, 1);
    single_v[7] = mk(0, 0, 8'h00, 1, 0, 8'h2A, 0, 1, 1);

    // WR_LOW_CYC=1, WR_HIGH_CYC=3: two back-to-back words, period 5
    param_v[0]  = mk(1, 1, 8'h5A, 1, 1, 8'h00, 0, 1, 1);
    param_v[1]  = mk(1, 0, 8'hA5, 1, 1, 8'h00, 0, 0, 1);
    param_v[2]  = mk(0, 0, 8'h00, 1, 1, 8'h5A, 0, 0, 1);
    param_v[3]  = mk(0, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 1);
    param_v[4]  = mk(0, 0, 8'h00, 1, 1, 8'h5A, 1, 0, 1);
    param_v[5]  = mk(0, 0, 8'h00, 1, 1, 8'h5A, 0, 0, 1);
    param_v[6]  = mk(0, 0, 8'h00, 1, 1, 8'h5A, 0, 0, 1);
    param_v[7]  = mk(0, 0, 8'h00, 1, 0, 8'hA5, 0, 0, 1);
    param_v[8]  = mk(0, 0, 8'h00, 0, 0, 8'hA5, 0, 0, 1);
    param_v[9]  = mk(0, 0, 8'h00, 1, 0, 8'hA5, 1, 0, 1);
    param_v[10] = mk(0, 0, 8'h00, 1, 0, 8'hA5, 0, 0, 1);
    param_v[11] = mk(0, 0, 8'h00, 1, 0, 8'hA5, 0, 0, 1);
    param_v[12] = mk(0, 0, 8'h00, 1, 0, 8'hA5, 0, 1, 1);

    repeat (3) step();
    reset = 1'b0;

    // Single command byte, cycle-exact
    for (int i = 0; i < 8; i++) begin
      in_valid = single_v[i].vld; in_dcx = single_v[i].vdcx; in_data = single_v[i].vdata;
      #1;
      check($sformatf("single[%0d]", i), {wr, dcx, D, tx_done, idle, in_ready}, single_v[i].exp);
      step();
    end
    in_valid = 1'b0;

    // Alternate hold times on the second instance
    for (int i = 0; i < 13; i++) begin
      p_valid = param_v[i].vld; p_dcx = param_v[i].vdcx; p_data = param_v[i].vdata;
      #1;
      check($sformatf("param[%0d]", i), {p_wr, p_dcx_o, p_D, p_tx, p_idle, p_ready}, param_v[i].exp);
      step();
    end
    p_valid = 1'b0;

    // Burst of 6 data bytes with in_valid held
    k = 0; t0 = cyc; start_tx = tx_cnt; saw_full = 1'b0; last_b = 0;
    in_dcx = 1'b1;
    while ((k < 6 || tx_cnt - start_tx < 6) && cyc - t0 < 100) begin
      in_valid = (k < 6);
      in_data = 8'h10 + 8'(k);
      #1;
      if (k < 6 && !in_ready && !saw_full) begin
        saw_full = 1'b1;
        check("burst_full_at", k, 5);
      end
      if (in_valid && in_ready) k++;
      w = 9'(tx_cnt);
      step();
      if (9'(tx_cnt) != w) begin
        if (tx_cnt - start_tx > 1) check("burst_gap", cyc - last_b, 5);
        last_b = cyc;
      end
    end
    in_valid = 1'b0;
    check("burst_count", tx_cnt - start_tx, 6);
    check("burst_backpressure", saw_full, 1'b1);
    t0 = cyc;
    while (!idle && cyc - t0 < 20) step();
    check("burst_idle", idle, 1'b1);

    // Flush during LOW of the first of four words
    start_tx = tx_cnt;
    in_dcx = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h20 + 8'(i);
      step();
    end
    check("flush_in_low", wr, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    #1;
    check("flush_ready", in_ready, 1'b0);
    w = exp_q[0];
    exp_q.delete();
    exp_q.push_back(w);
    step();
    flush = 1'b0; in_valid = 1'b0;
    low_cnt = 0;
    repeat (15) begin
      step();
      if (!wr) low_cnt++;
    end
    check("flush_tx_count", tx_cnt - start_tx, 1);
    check("flush_no_wr", low_cnt, 0);
    check("flush_idle", idle, 1'b1);
    check("flush_sb_empty", exp_q.size(), 0);

    // Reset while wr is low
    in_dcx = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'h31 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    t0 = cyc;
    while (wr && cyc - t0 < 10) step();
    check("reset_in_low", wr, 1'b0);
    start_tx = tx_cnt;
    reset = 1'b1;
    #1;
    check("reset_ready_low", in_ready, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("reset_mid", {wr, dcx, D, tx_done, idle, in_ready}, {1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1});
    low_cnt = 0;
    repeat (20) begin
      step();
      if (!wr) low_cnt++;
    end
    check("reset_no_wr", low_cnt, 0);
    check("reset_no_tx", tx_cnt - start_tx, 0);

    // Full FIFO with in_valid held across pops
    k = 0; t0 = cyc; start_tx = tx_cnt; prev_rdy = 1'b1;
    while ((k < 8 || tx_cnt - start_tx < 8) && cyc - t0 < 150) begin
      in_valid = (k < 8);
      in_dcx = k[0];
      in_data = 8'h40 + 8'(k);
      #1;
      if (k < 8 && in_ready && !prev_rdy) check("ready_rise_after_pop", cyc - last_tx, 2);
      if (k < 8) prev_rdy = in_ready;
      if (in_valid && in_ready) k++;
      step();
      check("occupancy_le_5", (k - (tx_cnt - start_tx)) > 5, 1'b0);
    end
    in_valid = 1'b0;
    check("pp_count", tx_cnt - start_tx, 8);
    t0 = cyc;
    while (!idle && cyc - t0 < 20) step();
    check("pp_idle", idle, 1'b1);
    check("pp_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
